stream_golden_checker: RTL and testbench

STREAM_GOLDEN_CHECKER -- requirements
Module: stream_golden_checker

---
 rtl/stream_golden_checker.sv | 147 ++++++++++++++
 tb/tb_stream_golden_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_golden_checker.sv
// Compares an AXI4-Stream sink against a preloaded golden memory and reports PASS/FAIL/TOUT.
// Optional macro STREAM_CHECKER_LAST_CHECK_EN also checks in_last against the final-beat position.
module stream_golden_checker #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 1536,
    parameter int ADDR_W      = 11,
    parameter int TIMEOUT     = 75000,
    parameter int READY_MODE  = 0,
    parameter int STOP_ON_ERR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              golden_we,
    input  logic [ADDR_W-1:0] golden_addr,
    input  logic [DATA_W-1:0] golden_wdata,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W:0]   beat_cnt,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic [DATA_W-1:0] first_err_data
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic              alt;
    logic [WD_W-1:0]   wd;
    logic [DATA_W-1:0] golden_rd;
    logic              rdy_pat;
    logic              accept;
    logic              final_beat;
    logic              beat_fail;
    logic              any_fail;

    always_comb begin
        golden_rd = mem[beat_cnt[MEM_AW-1:0]];
        case (READY_MODE)
            1:       rdy_pat = lfsr[0];
            2:       rdy_pat = alt;
            default: rdy_pat = 1'b1;
        endcase
        in_ready   = (state == S_RUN) && rdy_pat;
        accept     = in_valid && in_ready;
        final_beat = (beat_cnt == LAST_IDX);
`ifdef STREAM_CHECKER_LAST_CHECK_EN
        beat_fail  = (in_data != golden_rd) || (in_last != final_beat);
`else
        beat_fail  = (in_data != golden_rd);
`endif
        any_fail   = beat_fail || (err_cnt != 16'd0);
        // Fibonacci taps 16,14,13,11 expressed as a right shift
        lfsr_next  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

`ifndef STREAM_CHECKER_LAST_CHECK_EN
    logic unused_last;
    assign unused_last = in_last;
`endif

    // Golden memory is writable only while no run is in progress; not cleared by reset.
    always_ff @(posedge clock) begin
        if (golden_we && (state != S_RUN) && ({1'b0, golden_addr} < DEPTH_V))
            mem[golden_addr[MEM_AW-1:0]] <= golden_wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            beat_cnt       <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            lfsr           <= 16'hACE1;
            alt            <= 1'b1;
            wd             <= '0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                S_RUN: begin
                    alt <= ~alt;
                    if (accept) begin
                        wd       <= '0;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_fail) begin
                            if (err_cnt != 16'hFFFF)
                                err_cnt <= err_cnt + 16'd1;
                            if (err_cnt == 16'd0) begin
                                first_err_idx  <= beat_cnt[ADDR_W-1:0];
                                first_err_data <= in_data;
                            end
                        end
                        // The final beat takes priority over a coincident watchdog expiry.
                        if (final_beat) begin
                            state <= any_fail ? S_FAIL : S_PASS;
                            done  <= 1'b1;
                            pass  <= ~any_fail;
                        end else if ((STOP_ON_ERR != 0) && beat_fail) begin
                            state <= S_FAIL;
                            done  <= 1'b1;
                        end
                    end else if (TIMEOUT != 0) begin
                        if (wd == WD_LAST) begin
                            state   <= S_TOUT;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end else begin
                            wd <= wd + 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state          <= S_RUN;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        err_cnt        <= '0;
                        beat_cnt       <= '0;
                        first_err_idx  <= '0;
                        first_err_data <= '0;
                        lfsr           <= 16'hACE1;
                        alt            <= 1'b1;
                        wd             <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stream_golden_checker.sv
// Bench for stream_golden_checker: four instances (plain, stop-on-error, LFSR ready, alternating ready)
// driven by a directed table, a reset sequence and randomized runs checked against a reference model.
module tb_stream_golden_checker;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 11;
    localparam int TO    = 20;
    localparam int NI    = 4;
`ifdef STREAM_CHECKER_LAST_CHECK_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic          start_a [NI];
    logic          gwe_a   [NI];
    logic [AW-1:0] gaddr_a [NI];
    logic [DW-1:0] gwd_a   [NI];
    logic          val_a   [NI];
    logic [DW-1:0] dat_a   [NI];
    logic          last_a  [NI];
    logic          rdy_a   [NI];
    logic          done_a  [NI];
    logic          pass_a  [NI];
    logic          tout_a  [NI];
    logic [15:0]   err_a   [NI];
    logic [AW:0]   beats_a [NI];
    logic [AW-1:0] fidx_a  [NI];
    logic [DW-1:0] fdat_a  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        stream_golden_checker #(
            .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TO),
            .READY_MODE((g == 2) ? 1 : ((g == 3) ? 2 : 0)),
            .STOP_ON_ERR((g == 1) ? 1 : 0)
        ) u_dut (
            .clock(clock), .reset(reset), .start(start_a[g]),
            .golden_we(gwe_a[g]), .golden_addr(gaddr_a[g]), .golden_wdata(gwd_a[g]),
            .in_valid(val_a[g]), .in_data(dat_a[g]), .in_last(last_a[g]),
            .in_ready(rdy_a[g]), .done(done_a[g]), .pass(pass_a[g]), .timeout(tout_a[g]),
            .err_cnt(err_a[g]), .beat_cnt(beats_a[g]),
            .first_err_idx(fidx_a[g]), .first_err_data(fdat_a[g])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] gold [NI][DEPTH];
    logic [15:0] tx [DEPTH];
    int m_pass, m_tout, m_err, m_beats, m_fidx, m_fdata;

    typedef struct {
        int               g;
        logic [3:0][15:0] d;
        int               n_send;
        int               last_bad;
        bit               wr_run;
        bit               e_pass;
        bit               e_tout;
        int               e_err;
        int               e_beats;
        int               e_fidx;
        int               e_fdata;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(int g, int d0, int d1, int d2, int d3, int n, int lb, bit wr,
                                bit p, bit t, int err, int beats, int fidx, int fdata);
        vec_t v;
        v.g = g;
        v.d[0] = 16'(d0); v.d[1] = 16'(d1); v.d[2] = 16'(d2); v.d[3] = 16'(d3);
        v.n_send = n; v.last_bad = lb; v.wr_run = wr;
        v.e_pass = p; v.e_tout = t; v.e_err = err; v.e_beats = beats;
        v.e_fidx = fidx; v.e_fdata = fdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic write_golden(input int g);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            gwe_a[g] = 1'b1; gaddr_a[g] = AW'(i); gwd_a[g] = gold[g][i];
        end
        // address beyond DEPTH must not alias onto a real entry
        @(negedge clock);
        gaddr_a[g] = AW'(DEPTH); gwd_a[g] = 16'hBEEF;
        @(negedge clock);
        gwe_a[g] = 1'b0;
    endtask

    // Reference model: ready pattern from mode rules, beat k compared against gold[g][k].
    task automatic run_stream(input int g, input int n_send, input int vprob, input int last_bad,
                              input bit wr_run);
        int  mode;
        int  lf, fb, k, idle, cyc;
        bit  stop, ended, alt, r, v, lst, f, acc;
        mode = (g == 2) ? 1 : ((g == 3) ? 2 : 0);
        stop = (g == 1);
        lf = 'hACE1; alt = 1'b1; k = 0; idle = 0; cyc = 0; ended = 1'b0;
        m_pass = 0; m_tout = 0; m_err = 0; m_fidx = 0; m_fdata = 0;
        @(negedge clock) start_a[g] = 1'b1;
        @(negedge clock) start_a[g] = 1'b0;
        while (!ended && cyc < 200) begin
            r   = (mode == 1) ? bit'(lf & 1) : ((mode == 2) ? alt : 1'b1);
            v   = (k < n_send) && (int'($urandom_range(99)) < vprob);
            lst = (last_bad >= 0) ? (k == last_bad) : (k == DEPTH - 1);
            val_a[g]  = v;
            dat_a[g]  = (k < DEPTH) ? tx[k] : 16'($urandom);
            last_a[g] = lst;
            if (wr_run) begin
                gwe_a[g] = 1'b1; gaddr_a[g] = AW'(3); gwd_a[g] = 16'hDEAD;
            end
            #1;
            chk("in_ready", 32'(rdy_a[g]), 32'(r));
            chk("done_during_run", 32'(done_a[g]), 0);
            acc = v && r;
            cyc++;
            if (acc) begin
                f = (tx[k] != gold[g][k]) || (LAST_EN && (lst != (k == DEPTH - 1)));
                if (f) begin
                    if (m_err == 0) begin m_fidx = k; m_fdata = int'(tx[k]); end
                    m_err++;
                end
                k++;
                idle = 0;
                if (k == DEPTH || (stop && f)) begin
                    ended  = 1'b1;
                    m_pass = (m_err == 0) ? 1 : 0;
                end
            end else begin
                idle++;
                if (idle == TO) begin ended = 1'b1; m_tout = 1; end
            end
            fb  = ((lf >> 0) ^ (lf >> 2) ^ (lf >> 3) ^ (lf >> 5)) & 1;
            lf  = (lf >> 1) | (fb << 15);
            alt = !alt;
            @(negedge clock);
        end
        val_a[g] = 1'b0;
        gwe_a[g] = 1'b0;
        m_beats  = k;
        #1;
        chk("done", 32'(done_a[g]), 1);
        chk("pass", 32'(pass_a[g]), 32'(m_pass));
        chk("timeout", 32'(tout_a[g]), 32'(m_tout));
        chk("err_cnt", 32'(err_a[g]), 32'(m_err));
        chk("beat_cnt", 32'(beats_a[g]), 32'(m_beats));
        chk("first_err_idx", 32'(fidx_a[g]), 32'(m_fidx));
        chk("first_err_data", 32'(fdat_a[g]), 32'(m_fdata));
        chk("ready_after_end", 32'(rdy_a[g]), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit: actual expired required finish");
        $fatal(1, "time limit");
    end

    initial begin
        int g, n, lb;
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_a[i] = 0; gwe_a[i] = 0; gaddr_a[i] = '0; gwd_a[i] = '0;
            val_a[i] = 0; dat_a[i] = '0; last_a[i] = 0;
        end
        repeat (2) @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            chk("rst_ready", 32'(rdy_a[i]), 0);
            chk("rst_done", 32'(done_a[i]), 0);
            chk("rst_err", 32'(err_a[i]), 0);
            chk("rst_beats", 32'(beats_a[i]), 0);
        end
        reset = 1'b0;

        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < DEPTH; k++) gold[i][k] = 16'(k + 1);
            write_golden(i);
        end

        tbl[0] = mk(0, 1, 2, 3, 4, 4, -1, 0, 1, 0, 0, 4, 0, 0);
        tbl[1] = mk(0, 1, 9, 3, 7, 4, -1, 0, 0, 0, 2, 4, 1, 9);
        tbl[2] = mk(1, 1, 9, 3, 7, 4, -1, 0, 0, 0, 1, 2, 1, 9);
        tbl[3] = mk(0, 1, 2, 3, 4, 2, -1, 0, 0, 1, 0, 2, 0, 0);
        tbl[4] = mk(2, 1, 2, 3, 4, 4, -1, 0, 1, 0, 0, 4, 0, 0);
        tbl[5] = mk(3, 1, 2, 3, 4, 4, -1, 0, 1, 0, 0, 4, 0, 0);
`ifdef STREAM_CHECKER_LAST_CHECK_EN
        tbl[6] = mk(0, 1, 2, 3, 4, 4, 2, 0, 0, 0, 2, 4, 2, 3);
`else
        tbl[6] = mk(0, 1, 2, 3, 4, 4, 2, 0, 1, 0, 0, 4, 0, 0);
`endif
        tbl[7] = mk(1, 1, 2, 3, 4, 4, -1, 1, 1, 0, 0, 4, 0, 0);
        tbl[8] = mk(0, 5, 2, 3, 4, 4, -1, 0, 0, 0, 1, 4, 0, 5);

        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < DEPTH; k++) tx[k] = tbl[i].d[k];
            run_stream(tbl[i].g, tbl[i].n_send, 100, tbl[i].last_bad, tbl[i].wr_run);
            g = tbl[i].g;
            chk("tbl_pass", 32'(pass_a[g]), 32'(tbl[i].e_pass));
            chk("tbl_timeout", 32'(tout_a[g]), 32'(tbl[i].e_tout));
            chk("tbl_err_cnt", 32'(err_a[g]), 32'(tbl[i].e_err));
            chk("tbl_beat_cnt", 32'(beats_a[g]), 32'(tbl[i].e_beats));
            chk("tbl_first_err_idx", 32'(fidx_a[g]), 32'(tbl[i].e_fidx));
            chk("tbl_first_err_data", 32'(fdat_a[g]), 32'(tbl[i].e_fdata));
        end

        // Reset in the middle of a run that already has an error recorded
        tx[0] = 16'd1; tx[1] = 16'd9; tx[2] = 16'd3; tx[3] = 16'd4;
        @(negedge clock) start_a[0] = 1'b1;
        @(negedge clock) start_a[0] = 1'b0;
        val_a[0] = 1'b1; dat_a[0] = tx[0]; last_a[0] = 1'b0;
        @(negedge clock) dat_a[0] = tx[1];
        @(negedge clock) val_a[0] = 1'b0;
        chk("pre_rst_err", 32'(err_a[0]), 1);
        chk("pre_rst_beats", 32'(beats_a[0]), 2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(rdy_a[0]), 0);
        chk("mid_rst_done", 32'(done_a[0]), 0);
        chk("mid_rst_pass", 32'(pass_a[0]), 0);
        chk("mid_rst_timeout", 32'(tout_a[0]), 0);
        chk("mid_rst_err", 32'(err_a[0]), 0);
        chk("mid_rst_beats", 32'(beats_a[0]), 0);
        chk("mid_rst_fidx", 32'(fidx_a[0]), 0);
        chk("mid_rst_fdata", 32'(fdat_a[0]), 0);
        chk("mid_rst_other_done", 32'(done_a[2]), 0);
        @(negedge clock) reset = 1'b0;
        tx[1] = 16'd2;
        run_stream(0, 4, 100, -1, 1'b0);
        chk("post_rst_pass", 32'(pass_a[0]), 1);

        for (int it = 0; it < 24; it++) begin
            g = it % NI;
            for (int k = 0; k < DEPTH; k++) gold[g][k] = 16'($urandom);
            write_golden(g);
            for (int k = 0; k < DEPTH; k++)
                tx[k] = ($urandom_range(3) == 0) ? 16'($urandom) : gold[g][k];
            lb = (LAST_EN && $urandom_range(3) == 0) ? int'($urandom_range(3)) : -1;
            n  = ($urandom_range(5) == 0) ? int'($urandom_range(3)) : DEPTH;
            run_stream(g, n, int'($urandom_range(100, 40)), lb, bit'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
